// File: rtl/eng_outbuf_if.sv
// Engine/host handshake bundle around the output buffer.
//
// Handshake semantics: the engine side is request/acknowledge. A beat on
// eng_outbuf_dout_reg is taken at a rising edge when eng_outbuf_wr_req=1 and
// outbuf_eng_full=0. outbuf_eng_wr_ack pulses for one cycle afterwards. A
// request made while full is dropped, not held.
// The host side is valid/ready. outbuf_host_dout is meaningful whenever
// outbuf_host_dout_val=1. It transfers at a rising edge when
// outbuf_host_dout_val=1 and host_outbuf_rd_rdy=1. The ready input may be
// high without valid; that has no effect.
interface eng_outbuf_if #(
    parameter int PCK_TREE_XOR_UNITS_NUM = 128,
    parameter int W                      = 4,
    parameter int PACKET_LENGTH          = 2
);
    logic [PACKET_LENGTH-1:0] eng_outbuf_dout_reg [0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1];
    logic                     eng_outbuf_wr_req;
    logic                     outbuf_eng_wr_ack;
    logic                     outbuf_eng_full;
    logic [PACKET_LENGTH-1:0] outbuf_host_dout [0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1];
    logic                     outbuf_host_dout_val;
    logic                     host_outbuf_rd_rdy;

    // Buffer-side view
    modport slave (
        input  eng_outbuf_dout_reg,
        input  eng_outbuf_wr_req,
        input  host_outbuf_rd_rdy,
        output outbuf_eng_wr_ack,
        output outbuf_eng_full,
        output outbuf_host_dout,
        output outbuf_host_dout_val
    );

    // Environment-side view (engine plus host)
    modport master (
        output eng_outbuf_dout_reg,
        output eng_outbuf_wr_req,
        output host_outbuf_rd_rdy,
        input  outbuf_eng_wr_ack,
        input  outbuf_eng_full,
        input  outbuf_host_dout,
        input  outbuf_host_dout_val
    );
endinterface

// File: rtl/eng_outbuf.sv
// Output buffer between the tree-xor engine and the host.
// This is a circular FIFO with first-word-fall-through reads and no
// write-to-read bypass. Full/empty come only from the registered count.
// The buffer has a sticky overflow flag and a synchronous flush shared with
// the engine.
// OUTBUF_DEPTH must be a power of two and at least 2. The pointers rely on
// natural binary wrap.
module eng_outbuf #(
    parameter int PCK_TREE_XOR_UNITS_NUM = 128,
    parameter int W                      = 4,
    parameter int PACKET_LENGTH          = 2,
    parameter int OUTBUF_DEPTH           = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            eng_rstn,
    eng_outbuf_if.slave                     bus,
    output logic [$clog2(OUTBUF_DEPTH):0]   outbuf_cnt,
    output logic                            outbuf_empty,
    output logic                            outbuf_err_ovf,
    input  logic                            outbuf_err_clr
);
    localparam int AW = $clog2(OUTBUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUTBUF_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Storage is not reset. Only pointers and count decide what is valid.
    logic [PACKET_LENGTH-1:0] mem [0:OUTBUF_DEPTH-1][0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          ack_q,    ack_d;
    logic          ovf_q,    ovf_d;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;
    logic ovf_set;

    // Status decode from registered count only, so a same-cycle read never
    // unblocks a write
    always_comb begin
        full  = (cnt_q == DEPTH_C);
        empty = (cnt_q == '0);
    end

    // Transfer qualification. The flush masks both ports and the overflow
    // detect.
    always_comb begin
        wr_acc  = eng_rstn & bus.eng_outbuf_wr_req & ~full;
        rd_acc  = eng_rstn & bus.host_outbuf_rd_rdy & ~empty;
        ovf_set = eng_rstn & bus.eng_outbuf_wr_req & full;
    end

    // Next-state for pointers, count, ack pulse and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        ovf_d    = ovf_q;
        if (!eng_rstn) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ack_d    = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (rd_acc && !wr_acc) begin
                cnt_d = cnt_q - CNT_ONE;
            end
            ack_d = wr_acc;
            // A new overflow in the same cycle as a clear keeps the flag set
            if (ovf_set) begin
                ovf_d = 1'b1;
            end else if (outbuf_err_clr) begin
                ovf_d = 1'b0;
            end
        end
    end

    // Control state. An async reset discards entries and any pending ack at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage: an accepted beat lands at wr_ptr
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < PCK_TREE_XOR_UNITS_NUM; i++) begin
                for (int j = 0; j < W; j++) begin
                    mem[wr_ptr_q][i][j] <= bus.eng_outbuf_dout_reg[i][j];
                end
            end
        end
    end

    // Head entry presented combinationally from storage. There is no
    // bypass, so new data shows one cycle after the write.
    always_comb begin
        for (int i = 0; i < PCK_TREE_XOR_UNITS_NUM; i++) begin
            for (int j = 0; j < W; j++) begin
                bus.outbuf_host_dout[i][j] = mem[rd_ptr_q][i][j];
            end
        end
    end

    // Output drive
    always_comb begin
        bus.outbuf_eng_wr_ack    = ack_q;
        bus.outbuf_eng_full      = full;
        bus.outbuf_host_dout_val = ~empty;
        outbuf_cnt               = cnt_q;
        outbuf_empty             = empty;
        outbuf_err_ovf           = ovf_q;
    end
endmodule

// File: tb/tb_eng_outbuf.sv
// Self-checking bench for eng_outbuf with a four-entry buffer and a small
// beat of 8 x 4 x 2 bits.
module tb_eng_outbuf;
    localparam int N     = 8;
    localparam int WW    = 4;
    localparam int PL    = 2;
    localparam int DEPTH = 4;
    localparam int EW    = N * WW * PL;

    logic clk;
    logic rstn;
    logic eng_rstn;
    logic outbuf_err_clr;
    logic [$clog2(DEPTH):0] outbuf_cnt;
    logic outbuf_empty;
    logic outbuf_err_ovf;
    logic [EW-1:0] din_flat;

    int checks;
    int errors;

    logic [EW-1:0] exp_q[$];
    bit            m_ack;
    bit            m_err;

    eng_outbuf_if #(.PCK_TREE_XOR_UNITS_NUM(N), .W(WW), .PACKET_LENGTH(PL)) bus ();

    eng_outbuf #(
        .PCK_TREE_XOR_UNITS_NUM(N),
        .W(WW),
        .PACKET_LENGTH(PL),
        .OUTBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .eng_rstn(eng_rstn),
        .bus(bus),
        .outbuf_cnt(outbuf_cnt),
        .outbuf_empty(outbuf_empty),
        .outbuf_err_ovf(outbuf_err_ovf),
        .outbuf_err_clr(outbuf_err_clr)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Spread the flat stimulus word over the beat array
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < WW; j++) begin
                bus.eng_outbuf_dout_reg[i][j] = din_flat[(i*WW+j)*PL +: PL];
            end
        end
    end

    function automatic logic [EW-1:0] head_flat();
        logic [EW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < WW; j++) begin
                f[(i*WW+j)*PL +: PL] = bus.outbuf_host_dout[i][j];
            end
        end
        return f;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Compare all observable state against the scoreboard
    task automatic check_outputs(input string ph);
        int sz;
        sz = exp_q.size();
        check_val({ph, ":cnt"},   64'(outbuf_cnt), 64'(sz));
        check_val({ph, ":full"},  64'(bus.outbuf_eng_full), 64'(sz == DEPTH));
        check_val({ph, ":empty"}, 64'(outbuf_empty), 64'(sz == 0));
        check_val({ph, ":val"},   64'(bus.outbuf_host_dout_val), 64'(sz != 0));
        check_val({ph, ":ack"},   64'(bus.outbuf_eng_wr_ack), 64'(m_ack));
        check_val({ph, ":err"},   64'(outbuf_err_ovf), 64'(m_err));
        if (sz != 0) begin
            check_val({ph, ":dout"}, 64'(head_flat()), 64'(exp_q[0]));
        end
    endtask

    // One cycle: drive after the falling edge, check, update the model,
    // then cross the rising edge
    task automatic step(input string ph, input bit wr, input logic [EW-1:0] d,
                        input bit rd, input bit clr, input bit flush);
        bit full_m;
        bit acc_w;
        bit acc_r;
        bus.eng_outbuf_wr_req  = wr;
        din_flat               = d;
        bus.host_outbuf_rd_rdy = rd;
        outbuf_err_clr         = clr;
        eng_rstn               = ~flush;
        #1;
        check_outputs(ph);
        if (flush) begin
            exp_q.delete();
            m_ack = 1'b0;
            m_err = 1'b0;
        end else begin
            full_m = (exp_q.size() == DEPTH);
            acc_w  = wr && !full_m;
            acc_r  = rd && (exp_q.size() != 0);
            if (acc_r) void'(exp_q.pop_front());
            if (acc_w) exp_q.push_back(d);
            m_ack = acc_w;
            if (wr && full_m) m_err = 1'b1;
            else if (clr)     m_err = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [EW-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [EW-1:0] d9;
        checks = 0;
        errors = 0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        rstn   = 1'b0;
        eng_rstn = 1'b1;
        outbuf_err_clr = 1'b0;
        bus.eng_outbuf_wr_req  = 1'b0;
        bus.host_outbuf_rd_rdy = 1'b0;
        din_flat = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Fill four entries with no reads
        for (int k = 0; k < DEPTH; k++) step("fill", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("fill_done", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Overflow while full; the dropped word must never appear
        step("ovf", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("ovf_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("underflow", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("err_clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step("err_cleared", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Simultaneous read and write at cnt=2 with pointer wrap
        step("pre2", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("pre2", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step("simul", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);

        // Full plus read in the same cycle: the read wins and the write drops
        step("to_full", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("to_full", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("full_rd", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
        step("full_rd_after", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Flush with cnt=3 and a write request present
        step("flush", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b1);
        d9 = rnd_word();
        step("post_flush_wr", 1'b1, d9, 1'b0, 1'b0, 1'b0);
        step("post_flush_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("post_flush_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // A clear coinciding with a new overflow leaves the flag set
        for (int k = 0; k < DEPTH; k++) step("refill", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("ovf_and_clr", 1'b1, rnd_word(), 1'b0, 1'b1, 1'b0);
        step("ovf_and_clr_after", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("flush2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            step("rand", 1'($urandom_range(0, 1)), rnd_word(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
        end
        step("rand_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with cnt=2 and an ack pending
        step("pre_async", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        step("pre_async", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
        bus.eng_outbuf_wr_req = 1'b0;
        #1;
        check_val("async_pre:ack", 64'(bus.outbuf_eng_wr_ack), 64'd1);
        check_val("async_pre:cnt", 64'(outbuf_cnt), 64'd2);
        #1;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        m_ack = 1'b0;
        m_err = 1'b0;
        check_outputs("async");
        @(negedge clk);
        rstn = 1'b1;
        d9 = rnd_word();
        step("post_async_wr", 1'b1, d9, 1'b0, 1'b0, 1'b0);
        step("post_async_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("end", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
